// File: rtl/uart_registro_datos_if.sv
// rtl/uart_registro_datos_if.sv - write-source and data-out bundle for the UART data register
interface uart_registro_datos_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] data_in1;
    logic [WIDTH-1:0] data_in2;
    logic             we1;
    logic             we2;
    logic [WIDTH-1:0] data_out;

    modport master (
        output data_in1,
        output data_in2,
        output we1,
        output we2,
        input  data_out
    );

    modport slave (
        input  data_in1,
        input  data_in2,
        input  we1,
        input  we2,
        output data_out
    );
endinterface

// File: rtl/uart_registro_datos.sv
// rtl/uart_registro_datos.sv - dual-source 32-bit holding register for the UART datapath
// Source 1 (bus side) wins over source 2 (receive side) when both write on one edge.
module uart_registro_datos #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    uart_registro_datos_if.slave  bus
);
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (bus.we1) begin
            data_d = bus.data_in1;
        end else if (bus.we2) begin
            data_d = bus.data_in2;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            data_q <= RESET_VALUE;
        end else begin
            data_q <= data_d;
        end
    end

    // Output comes straight from the flop so no input ever reaches data_out combinationally.
    assign bus.data_out = data_q;
endmodule

// File: tb/tb_uart_registro_datos.sv
// tb/tb_uart_registro_datos.sv - self-checking bench for uart_registro_datos
module tb_uart_registro_datos;
    logic clk;
    logic rst_n;

    uart_registro_datos_if #(.WIDTH(32)) bus ();

    uart_registro_datos #(
        .WIDTH(32),
        .RESET_VALUE(32'h0000_0000)
    ) dut (
        .clk_i  (clk),
        .reset_i(rst_n),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we1;
        logic        we2;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] exp;
    } vec_t;

    int          n_checks;
    int          n_errors;
    logic [31:0] sb_q[$];
    logic [31:0] last_exp;
    vec_t        vecs[20];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive on the falling edge, confirm the output has not moved yet, then compare after the rising edge.
    task automatic apply_vec(input string nm, input logic w1, input logic w2,
                             input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] exp);
        logic [31:0] want;
        @(negedge clk);
        bus.we1      = w1;
        bus.we2      = w2;
        bus.data_in1 = d1;
        bus.data_in2 = d2;
        sb_q.push_back(exp);
        #1;
        check({nm, "_pre_edge"}, bus.data_out, last_exp);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check({nm, "_sb_empty"}, 32'h1, 32'h0);
        end else begin
            want = sb_q.pop_front();
            check(nm, bus.data_out, want);
            last_exp = want;
        end
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        last_exp     = 32'h0;
        rst_n        = 1'b0;
        bus.we1      = 1'b0;
        bus.we2      = 1'b0;
        bus.data_in1 = 32'h0;
        bus.data_in2 = 32'h0;

        vecs[0]  = '{1'b1, 1'b0, 32'hABCDEF12, 32'h12345678, 32'hABCDEF12};
        vecs[1]  = '{1'b0, 1'b0, 32'hABCDEF12, 32'h12345678, 32'hABCDEF12};
        vecs[2]  = '{1'b0, 1'b0, 32'hABCDEF12, 32'h12345678, 32'hABCDEF12};
        vecs[3]  = '{1'b0, 1'b0, 32'hABCDEF12, 32'h12345678, 32'hABCDEF12};
        vecs[4]  = '{1'b0, 1'b0, 32'hABCDEF12, 32'h12345678, 32'hABCDEF12};
        vecs[5]  = '{1'b0, 1'b0, 32'hABCDEF12, 32'h12345678, 32'hABCDEF12};
        vecs[6]  = '{1'b0, 1'b1, 32'hABCDEF12, 32'h12345678, 32'h12345678};
        vecs[7]  = '{1'b0, 1'b0, 32'hABCDEF12, 32'h12345678, 32'h12345678};
        vecs[8]  = '{1'b1, 1'b1, 32'hABCDEF12, 32'h12345678, 32'hABCDEF12};
        vecs[9]  = '{1'b1, 1'b0, 32'h11111111, 32'h22222222, 32'h11111111};
        vecs[10] = '{1'b0, 1'b1, 32'h33333333, 32'h22222222, 32'h22222222};
        vecs[11] = '{1'b1, 1'b0, 32'hA5A5A5A5, 32'h0F0F0F0F, 32'hA5A5A5A5};
        vecs[12] = '{1'b1, 1'b0, 32'h5A5A5A5A, 32'h0F0F0F0F, 32'h5A5A5A5A};
        vecs[13] = '{1'b1, 1'b1, 32'hDEADBEEF, 32'h0F0F0F0F, 32'hDEADBEEF};
        vecs[14] = '{1'b0, 1'b1, 32'hDEADBEEF, 32'hCAFEF00D, 32'hCAFEF00D};
        vecs[15] = '{1'b0, 1'b1, 32'hDEADBEEF, 32'h87654321, 32'h87654321};
        vecs[16] = '{1'b1, 1'b0, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF};
        vecs[17] = '{1'b0, 1'b1, 32'hFFFFFFFF, 32'h00000000, 32'h00000000};
        vecs[18] = '{1'b0, 1'b0, 32'h13579BDF, 32'h2468ACE0, 32'h00000000};
        vecs[19] = '{1'b0, 1'b1, 32'h13579BDF, 32'h12345678, 32'h12345678};

        // Reset held from time 0: writes must not land.
        #1;
        check("reset_initial", bus.data_out, 32'h0);
        apply_vec("reset_we1_a", 1'b1, 1'b0, 32'hABCDEF12, 32'h0, 32'h0);
        apply_vec("reset_we1_b", 1'b1, 1'b0, 32'hABCDEF12, 32'h0, 32'h0);

        // Release between edges with we1 still low so the release edge is idle.
        @(negedge clk);
        bus.we1 = 1'b0;
        rst_n   = 1'b1;

        for (int i = 0; i < 20; i++) begin
            apply_vec($sformatf("vec%0d", i), vecs[i].we1, vecs[i].we2,
                      vecs[i].d1, vecs[i].d2, vecs[i].exp);
        end

        // Asynchronous reset between edges, with writes attempted while held.
        @(negedge clk);
        bus.we1 = 1'b0;
        bus.we2 = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_before_edge", bus.data_out, 32'h0);
        last_exp = 32'h0;
        apply_vec("reset_hold_we1", 1'b1, 1'b0, 32'hABCDEF12, 32'h12345678, 32'h0);
        apply_vec("reset_hold_we2", 1'b0, 1'b1, 32'hABCDEF12, 32'h12345678, 32'h0);
        rst_n = 1'b1;
        apply_vec("release_edge_we2", 1'b0, 1'b1, 32'hABCDEF12, 32'h12345678, 32'h12345678);

        // Hold: inputs churn every cycle, enables low.
        for (int i = 0; i < 10; i++) begin
            apply_vec($sformatf("hold%0d", i), 1'b0, 1'b0, $urandom, $urandom, 32'h12345678);
        end

        // Reset asserted in the same cycle as a write: write is lost.
        @(negedge clk);
        bus.we1      = 1'b1;
        bus.data_in1 = 32'h0BADF00D;
        rst_n        = 1'b0;
        #1;
        check("reset_with_write_immediate", bus.data_out, 32'h0);
        @(posedge clk);
        #1;
        check("reset_with_write_edge", bus.data_out, 32'h0);
        last_exp = 32'h0;
        bus.we1  = 1'b0;
        rst_n    = 1'b1;
        apply_vec("post_reset_idle", 1'b0, 1'b0, 32'h0BADF00D, 32'h0, 32'h0);
        apply_vec("post_reset_we1", 1'b1, 1'b0, 32'h0BADF00D, 32'h0, 32'h0BADF00D);

        check("scoreboard_drained", 32'(sb_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
